// File: rtl/bus_master_arbiter_pkg.sv
// Shared bus constants: word widths, active-low enables, access directions
// and the owner encoding used by the arbiter and its mux.
package bus_master_arbiter_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned BUS_OWNER_W = 2;

  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic READ         = 1'b1;
  localparam logic WRITE        = 1'b0;
  localparam logic RESET_ENABLE = 1'b0;

  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

endpackage

// File: rtl/bus_master_mux.sv
// Combinational 4:1 selection of master-side access signals by owner index.
module bus_master_mux
  import bus_master_arbiter_pkg::*;
(
  input  logic [BUS_OWNER_W-1:0] owner,
  input  logic [WORD_ADDR_W-1:0] M0Addr,
  input  logic                   M0As_,
  input  logic                   M0RW,
  input  logic [WORD_DATA_W-1:0] M0WrData,
  input  logic [WORD_ADDR_W-1:0] M1Addr,
  input  logic                   M1As_,
  input  logic                   M1RW,
  input  logic [WORD_DATA_W-1:0] M1WrData,
  input  logic [WORD_ADDR_W-1:0] M2Addr,
  input  logic                   M2As_,
  input  logic                   M2RW,
  input  logic [WORD_DATA_W-1:0] M2WrData,
  input  logic [WORD_ADDR_W-1:0] M3Addr,
  input  logic                   M3As_,
  input  logic                   M3RW,
  input  logic [WORD_DATA_W-1:0] M3WrData,
  output logic [WORD_ADDR_W-1:0] SAddr,
  output logic                   SAs_,
  output logic                   SRW,
  output logic [WORD_DATA_W-1:0] SWrData
);

  always_comb begin
    SAddr   = M0Addr;
    SAs_    = M0As_;
    SRW     = M0RW;
    SWrData = M0WrData;
    case (owner)
      BUS_OWNER_MASTER_1: begin
        SAddr = M1Addr; SAs_ = M1As_; SRW = M1RW; SWrData = M1WrData;
      end
      BUS_OWNER_MASTER_2: begin
        SAddr = M2Addr; SAs_ = M2As_; SRW = M2RW; SWrData = M2WrData;
      end
      BUS_OWNER_MASTER_3: begin
        SAddr = M3Addr; SAs_ = M3As_; SRW = M3RW; SWrData = M3WrData;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Non-preemptive round-robin arbiter for four bus masters; grants and shared
// slave-side signals are decoded from the registered owner index.
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   M0Req_,
  input  logic                   M1Req_,
  input  logic                   M2Req_,
  input  logic                   M3Req_,
  input  logic [WORD_ADDR_W-1:0] M0Addr,
  input  logic [WORD_ADDR_W-1:0] M1Addr,
  input  logic [WORD_ADDR_W-1:0] M2Addr,
  input  logic [WORD_ADDR_W-1:0] M3Addr,
  input  logic                   M0As_,
  input  logic                   M1As_,
  input  logic                   M2As_,
  input  logic                   M3As_,
  input  logic                   M0RW,
  input  logic                   M1RW,
  input  logic                   M2RW,
  input  logic                   M3RW,
  input  logic [WORD_DATA_W-1:0] M0WrData,
  input  logic [WORD_DATA_W-1:0] M1WrData,
  input  logic [WORD_DATA_W-1:0] M2WrData,
  input  logic [WORD_DATA_W-1:0] M3WrData,
  output logic                   M0Grnt_,
  output logic                   M1Grnt_,
  output logic                   M2Grnt_,
  output logic                   M3Grnt_,
  output logic [WORD_ADDR_W-1:0] SAddr,
  output logic                   SAs_,
  output logic                   SRW,
  output logic [WORD_DATA_W-1:0] SWrData,
  output logic [BUS_OWNER_W-1:0] Owner
);

  logic [BUS_OWNER_W-1:0] owner_q;
  logic [BUS_OWNER_W-1:0] owner_d;
  logic [BUS_OWNER_W-1:0] cand;
  logic                   found;
  logic [3:0]             req_;

  assign req_ = {M3Req_, M2Req_, M1Req_, M0Req_};

  always_ff @(posedge clk or negedge reset_) begin
    if (reset_ == RESET_ENABLE) owner_q <= BUS_OWNER_MASTER_0;
    else                        owner_q <= owner_d;
  end

  // Owner holds while requesting; on release, scan owner+1..owner+3 in order.
  always_comb begin
    owner_d = owner_q;
    cand    = owner_q;
    found   = 1'b0;
    if (req_[owner_q] == DISABLE_) begin
      for (int unsigned i = 1; i < 4; i++) begin
        cand = owner_q + BUS_OWNER_W'(i);
        if (!found && (req_[cand] == ENABLE_)) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  assign Owner   = owner_q;
  assign M0Grnt_ = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
  assign M1Grnt_ = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
  assign M2Grnt_ = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
  assign M3Grnt_ = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

  bus_master_mux u_mux (
    .owner    (owner_q),
    .M0Addr   (M0Addr),
    .M0As_    (M0As_),
    .M0RW     (M0RW),
    .M0WrData (M0WrData),
    .M1Addr   (M1Addr),
    .M1As_    (M1As_),
    .M1RW     (M1RW),
    .M1WrData (M1WrData),
    .M2Addr   (M2Addr),
    .M2As_    (M2As_),
    .M2RW     (M2RW),
    .M2WrData (M2WrData),
    .M3Addr   (M3Addr),
    .M3As_    (M3As_),
    .M3RW     (M3RW),
    .M3WrData (M3WrData),
    .SAddr    (SAddr),
    .SAs_     (SAs_),
    .SRW      (SRW),
    .SWrData  (SWrData)
  );

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: reset, hand-off, no-preemption,
// fairness, owner re-request and asynchronous reset mid-access.
module tb_bus_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_;
  logic [3:0]  req_;
  logic [3:0]  as_;
  logic [3:0]  rw;
  logic [29:0] addr [4];
  logic [31:0] wdata [4];
  logic [3:0]  grnt_;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wrdata;
  logic [1:0]  owner;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bus_master_arbiter dut (
    .clk      (clk),
    .reset_   (reset_),
    .M0Req_   (req_[0]),
    .M1Req_   (req_[1]),
    .M2Req_   (req_[2]),
    .M3Req_   (req_[3]),
    .M0Addr   (addr[0]),
    .M1Addr   (addr[1]),
    .M2Addr   (addr[2]),
    .M3Addr   (addr[3]),
    .M0As_    (as_[0]),
    .M1As_    (as_[1]),
    .M2As_    (as_[2]),
    .M3As_    (as_[3]),
    .M0RW     (rw[0]),
    .M1RW     (rw[1]),
    .M2RW     (rw[2]),
    .M3RW     (rw[3]),
    .M0WrData (wdata[0]),
    .M1WrData (wdata[1]),
    .M2WrData (wdata[2]),
    .M3WrData (wdata[3]),
    .M0Grnt_  (grnt_[0]),
    .M1Grnt_  (grnt_[1]),
    .M2Grnt_  (grnt_[2]),
    .M3Grnt_  (grnt_[3]),
    .SAddr    (s_addr),
    .SAs_     (s_as_),
    .SRW      (s_rw),
    .SWrData  (s_wrdata),
    .Owner    (owner)
  );

  // Inputs change 1ns after a rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_   = 1'b1;
    req_     = 4'b1111;
    as_      = 4'b1111;
    rw       = 4'b0101;
    addr[0]  = 30'h100; addr[1]  = 30'h200; addr[2]  = 30'h300; addr[3]  = 30'h400;
    wdata[0] = 32'hA000_0000; wdata[1] = 32'hA111_1111;
    wdata[2] = 32'hA222_2222; wdata[3] = 32'hA333_3333;
    #1 reset_ = 1'b0;
    #1;
    vectors++;
    if (grnt_ !== 4'b1110) begin errors++; $display("FAIL reset_grnt got %b exp %b", grnt_, 4'b1110); end
    vectors++;
    if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    vectors++;
    if (s_addr !== 30'h100 || s_wrdata !== 32'hA000_0000 || s_rw !== 1'b1 || s_as_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_mux got addr %h data %h rw %b as %b exp 100 a0000000 1 1",
               s_addr, s_wrdata, s_rw, s_as_);
    end
    @(posedge clk); @(posedge clk);
    #2 reset_ = 1'b1;
    tick();
    vectors++;
    if (owner !== 2'd0) begin errors++; $display("FAIL post_reset_owner got %0d exp 0", owner); end
  endtask

  task automatic test_handoff();
    req_[2] = 1'b0;
    #3;
    vectors++;
    if (owner !== 2'd0) begin errors++; $display("FAIL handoff_before_edge got %0d exp 0", owner); end
    tick();
    vectors++;
    if (owner !== 2'd2 || grnt_ !== 4'b1011) begin
      errors++; $display("FAIL handoff_grant got owner %0d grnt %b exp 2 1011", owner, grnt_);
    end
    vectors++;
    if (s_addr !== 30'h300 || s_wrdata !== 32'hA222_2222 || s_rw !== 1'b1) begin
      errors++; $display("FAIL handoff_mux got %h %h %b exp 300 a2222222 1", s_addr, s_wrdata, s_rw);
    end
    // Non-owner inputs must not reach the shared bus.
    addr[0] = 30'h3FF_FFFF; as_[0] = 1'b0; rw[0] = 1'b0;
    #1;
    vectors++;
    if (s_addr !== 30'h300 || s_as_ !== 1'b1) begin
      errors++; $display("FAIL handoff_isolation got %h %b exp 300 1", s_addr, s_as_);
    end
    addr[0] = 30'h100; as_[0] = 1'b1; rw[0] = 1'b1;
  endtask

  task automatic test_no_preempt();
    int held = 0;
    req_ = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (owner == 2'd2) held++;
    end
    vectors++;
    if (held != 10) begin errors++; $display("FAIL no_preempt_hold got %0d of 10 exp 10", held); end
    req_[2] = 1'b1;
    tick();
    vectors++;
    if (owner !== 2'd3) begin errors++; $display("FAIL release_to_3 got %0d exp 3", owner); end
    req_[3] = 1'b1;
    tick();
    vectors++;
    if (owner !== 2'd0) begin errors++; $display("FAIL release_to_0 got %0d exp 0", owner); end
    req_[0] = 1'b1;
    tick();
    vectors++;
    if (owner !== 2'd1 || grnt_ !== 4'b1101) begin
      errors++; $display("FAIL release_to_1 got %0d %b exp 1 1101", owner, grnt_);
    end
    req_[1] = 1'b1;
    tick();
    vectors++;
    if (owner !== 2'd1) begin errors++; $display("FAIL idle_hold got %0d exp 1", owner); end
  endtask

  task automatic test_nearest_wins();
    // owner 1 idle, masters 0, 2, 3 requesting -> 2
    req_ = 4'b0010;
    tick();
    vectors++;
    if (owner !== 2'd2) begin errors++; $display("FAIL nearest_wins got %0d exp 2", owner); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_owner;
    reset_ = 1'b0;
    #1 reset_ = 1'b1;
    req_ = 4'b0000;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_owner = 2'(k % 4);
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (owner !== exp_owner) begin
          errors++; $display("FAIL fairness_hold k%0d got %0d exp %0d", k, owner, exp_owner);
        end
        tick();
      end
      req_[exp_owner] = 1'b1;
      tick();
      req_[exp_owner] = 1'b0;
    end
    vectors++;
    if (owner !== 2'd0) begin errors++; $display("FAIL fairness_end got %0d exp 0", owner); end
  endtask

  task automatic test_rerequest();
    int bad = 0;
    req_ = 4'b1101;
    tick();
    vectors++;
    if (owner !== 2'd1) begin errors++; $display("FAIL rereq_setup got %0d exp 1", owner); end
    for (int i = 0; i < 6; i++) begin
      req_[1] = ~req_[1];
      tick();
      if (owner !== 2'd1 || grnt_ !== 4'b1101) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL rereq_hold got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_async_reset();
    req_ = 4'b0111;
    tick();
    as_[3] = 1'b0;
    #1;
    vectors++;
    if (owner !== 2'd3 || s_as_ !== 1'b0 || s_addr !== 30'h400) begin
      errors++; $display("FAIL async_setup got %0d %b %h exp 3 0 400", owner, s_as_, s_addr);
    end
    #1 reset_ = 1'b0;
    #1;
    vectors++;
    if (owner !== 2'd0 || grnt_ !== 4'b1110 || s_as_ !== 1'b1 || s_addr !== 30'h100) begin
      errors++;
      $display("FAIL async_reset got owner %0d grnt %b as %b addr %h exp 0 1110 1 100",
               owner, grnt_, s_as_, s_addr);
    end
    #2 reset_ = 1'b1;
    as_[3] = 1'b1;
    req_ = 4'b1111;
    tick();
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_no_preempt();
    test_nearest_wins();
    test_fairness();
    test_rerequest();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
